// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared encodings for the load/store controller: access sizes and FSM states.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    // Natural alignment for the access size; the reserved size is never legal.
    function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: size_aligned = 1'b1;
            SZ_HALF: size_aligned = ~off[0];
            SZ_WORD: size_aligned = (off == 2'b00);
            default: size_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Byte-lane steering: store side builds byte-select and replicated data,
// load side picks the addressed lane and sign/zero-extends it.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_load,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] din,
    output logic [3:0]  sel,
    output logic [31:0] dout
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] st_data;
    logic [31:0] ld_data;

    always_comb begin
        sel     = '0;
        st_data = din;
        ld_data = din;
        case (off)
            2'd0:    lane_b = din[7:0];
            2'd1:    lane_b = din[15:8];
            2'd2:    lane_b = din[23:16];
            default: lane_b = din[31:24];
        endcase
        lane_h = off[1] ? din[31:16] : din[15:0];
        case (size)
            SZ_BYTE: begin
                sel     = 4'b0001 << off;
                st_data = {4{din[7:0]}};
                ld_data = {{24{lane_b[7] & ~uns}}, lane_b};
            end
            SZ_HALF: begin
                sel     = off[1] ? 4'b1100 : 4'b0011;
                st_data = {2{din[15:0]}};
                ld_data = {{16{lane_h[15] & ~uns}}, lane_h};
            end
            SZ_WORD: sel = 4'b1111;
            default: sel = '0;
        endcase
        dout = is_load ? ld_data : st_data;
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: request check, one-cycle memory issue, and a
// stallable response carrying extended load data or an error flag.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 20,
    parameter int MEM_DATA_BITS = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [31:0]              req_addr,
    input  logic [MEM_DATA_BITS-1:0] req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [MEM_DATA_BITS-1:0] resp_rdata,
    output logic                     resp_err,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic [MEM_DATA_BITS-1:0] mem_data_in,
    output logic [3:0]               mem_sel,
    output logic                     mem_str,
    output logic                     mem_ld,
    input  logic [MEM_DATA_BITS-1:0] mem_data_out
);

    localparam int HI_SHIFT = MEM_ADDR_BITS + 2;

    logic [1:0]               state_q;
    logic                     we_q;
    logic [1:0]               size_q;
    logic                     uns_q;
    logic [1:0]               off_q;
    logic [MEM_ADDR_BITS-1:0] waddr_q;
    logic [31:0]              wdata_q;
    logic                     err_q;
    logic                     first_q;
    logic [31:0]              rdata_q;

    logic        req_legal;
    logic        is_issue;
    logic        is_resp;
    logic [3:0]  st_sel;
    logic [3:0]  ld_sel;
    logic [31:0] st_lane;
    logic [31:0] ld_raw;
    logic [31:0] ld_ext;

    // Shifting by 32 (MEM_ADDR_BITS=30) yields zero, so the range check vanishes.
    assign req_legal = ((req_addr >> HI_SHIFT) == '0) && size_aligned(req_size, req_addr[1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        off_q   <= req_addr[1:0];
                        waddr_q <= req_addr[MEM_ADDR_BITS+1:2];
                        wdata_q <= req_wdata;
                        err_q   <= ~req_legal;
                        first_q <= 1'b1;
                        state_q <= req_legal ? ISSUE : RESP;
                    end
                end
                ISSUE: state_q <= RESP;
                RESP: begin
                    // Memory read data is only valid in the first RESP cycle; hold it for stalls.
                    if (first_q) begin
                        rdata_q <= mem_data_out;
                        first_q <= 1'b0;
                    end
                    if (resp_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ld_raw = first_q ? mem_data_out : rdata_q;

    lsu_align u_store_align (
        .is_load (1'b0),
        .size    (size_q),
        .off     (off_q),
        .uns     (1'b0),
        .din     (wdata_q),
        .sel     (st_sel),
        .dout    (st_lane)
    );

    lsu_align u_load_align (
        .is_load (1'b1),
        .size    (size_q),
        .off     (off_q),
        .uns     (uns_q),
        .din     (ld_raw),
        .sel     (ld_sel),
        .dout    (ld_ext)
    );

    assign is_issue = (state_q == ISSUE);
    assign is_resp  = (state_q == RESP);

    assign req_ready   = (state_q == IDLE);
    assign mem_addr    = is_issue ? waddr_q : '0;
    assign mem_sel     = is_issue ? (we_q ? st_sel : ld_sel) : '0;
    assign mem_data_in = is_issue ? st_lane : '0;
    assign mem_str     = is_issue & we_q;
    assign mem_ld      = is_issue & ~we_q;

    assign resp_valid = is_resp;
    assign resp_err   = is_resp & err_q;
    assign resp_rdata = (is_resp && !err_q && !we_q) ? ld_ext : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-masked, 1-cycle registered memory model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [19:0] mem_addr;
    logic [31:0] mem_data_in, mem_data_out;
    logic [3:0]  mem_sel;
    logic        mem_str, mem_ld;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.MEM_ADDR_BITS(20), .MEM_DATA_BITS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_sel(mem_sel), .mem_str(mem_str),
        .mem_ld(mem_ld), .mem_data_out(mem_data_out)
    );

    // Read data is masked by sel; a junk pattern appears when not reading.
    always @(posedge clk) begin : mem_model
        logic [31:0] m;
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem_data_out <= '0;
        end else begin
            for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{mem_sel[i]}};
            if (mem_str)
                for (int i = 0; i < 4; i++)
                    if (mem_sel[i]) mem[mem_addr[7:0]][8*i +: 8] <= mem_data_in[8*i +: 8];
            mem_data_out <= mem_ld ? (mem[mem_addr[7:0]] & m) : 32'hA5A5_A5A5;
        end
    end

    // Presents one request for a single edge; returns at the negedge after acceptance.
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if ({resp_valid, resp_err, mem_str, mem_ld, mem_sel} !== 8'h00) begin errors++; $display("FAIL reset_ctl got=%h exp=00", {resp_valid, resp_err, mem_str, mem_ld, mem_sel}); end
        checks++; if ({resp_rdata, mem_data_in, mem_addr} !== 84'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", {resp_rdata, mem_data_in, mem_addr}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word;
        send(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        checks++; if (mem_addr !== 20'h4) begin errors++; $display("FAIL word_st_addr got=%h exp=4", mem_addr); end
        checks++; if ({mem_str, mem_ld, mem_sel} !== 6'b10_1111) begin errors++; $display("FAIL word_st_ctl got=%b exp=101111", {mem_str, mem_ld, mem_sel}); end
        checks++; if (mem_data_in !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_st_data got=%h exp=deadbeef", mem_data_in); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL word_st_busy got=%b exp=0", req_ready); end
        @(negedge clk);
        checks++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'h0}) begin errors++; $display("FAIL word_st_resp got=%b/%b/%h exp=1/0/0", resp_valid, resp_err, resp_rdata); end
        @(negedge clk);
        checks++; if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("FAIL word_st_idle got=%b exp=10", {req_ready, resp_valid}); end
        send(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        checks++; if ({mem_str, mem_ld, mem_sel} !== 6'b01_1111) begin errors++; $display("FAIL word_ld_ctl got=%b exp=011111", {mem_str, mem_ld, mem_sel}); end
        @(negedge clk);
        checks++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin errors++; $display("FAIL word_ld_resp got=%b/%b/%h exp=1/0/deadbeef", resp_valid, resp_err, resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_byte;
        send(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_0080);
        checks++; if ({mem_addr, mem_sel} !== {20'h4, 4'b1000}) begin errors++; $display("FAIL byte_st_sel got=%h/%b exp=4/1000", mem_addr, mem_sel); end
        checks++; if (mem_data_in !== 32'h8080_8080) begin errors++; $display("FAIL byte_st_data got=%h exp=80808080", mem_data_in); end
        repeat (2) @(negedge clk);
        send(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0);
        @(negedge clk);
        checks++; if (resp_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL byte_ld_signed got=%h exp=ffffff80", resp_rdata); end
        @(negedge clk);
        send(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0);
        @(negedge clk);
        checks++; if (resp_rdata !== 32'h0000_0080) begin errors++; $display("FAIL byte_ld_unsigned got=%h exp=00000080", resp_rdata); end
        @(negedge clk);
        send(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0);
        checks++; if (mem_sel !== 4'b0001) begin errors++; $display("FAIL byte_ld_sel0 got=%b exp=0001", mem_sel); end
        @(negedge clk);
        checks++; if (resp_rdata !== 32'hFFFF_FFEF) begin errors++; $display("FAIL byte_ld_lane0 got=%h exp=ffffffef", resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_half;
        send(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h8001_7FFF);
        repeat (2) @(negedge clk);
        send(1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h0);
        checks++; if ({mem_addr, mem_sel} !== {20'h2, 4'b1100}) begin errors++; $display("FAIL half_hi_sel got=%h/%b exp=2/1100", mem_addr, mem_sel); end
        @(negedge clk);
        checks++; if (resp_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL half_hi_signed got=%h exp=ffff8001", resp_rdata); end
        @(negedge clk);
        send(1'b0, 2'b01, 1'b0, 32'h0000_0008, 32'h0);
        checks++; if (mem_sel !== 4'b0011) begin errors++; $display("FAIL half_lo_sel got=%b exp=0011", mem_sel); end
        @(negedge clk);
        checks++; if (resp_rdata !== 32'h0000_7FFF) begin errors++; $display("FAIL half_lo_signed got=%h exp=00007fff", resp_rdata); end
        @(negedge clk);
        send(1'b0, 2'b01, 1'b1, 32'h0000_000A, 32'h0);
        @(negedge clk);
        checks++; if (resp_rdata !== 32'h0000_8001) begin errors++; $display("FAIL half_hi_unsigned got=%h exp=00008001", resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_errors;
        logic        we_v   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]  size_v [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        logic [31:0] addr_v [4] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 32'h0040_0000};
        for (int i = 0; i < 4; i++) begin
            send(we_v[i], size_v[i], 1'b0, addr_v[i], 32'hFFFF_FFFF);
            checks++; if ({resp_valid, resp_err, resp_rdata} !== {2'b11, 32'h0}) begin errors++; $display("FAIL err_resp[%0d] got=%b/%b/%h exp=1/1/0", i, resp_valid, resp_err, resp_rdata); end
            checks++; if ({mem_str, mem_ld} !== 2'b00) begin errors++; $display("FAIL err_noaccess[%0d] got=%b exp=00", i, {mem_str, mem_ld}); end
            @(negedge clk);
            checks++; if ({req_ready, resp_valid, mem_str, mem_ld} !== 4'b1000) begin errors++; $display("FAIL err_idle[%0d] got=%b exp=1000", i, {req_ready, resp_valid, mem_str, mem_ld}); end
        end
        send(1'b0, 2'b10, 1'b0, 32'h003F_FFFC, 32'h0);
        checks++; if ({resp_valid, mem_ld, mem_addr} !== {2'b01, 20'hFFFFF}) begin errors++; $display("FAIL top_addr_issue got=%b/%b/%h exp=0/1/fffff", resp_valid, mem_ld, mem_addr); end
        @(negedge clk);
        checks++; if ({resp_valid, resp_err} !== 2'b10) begin errors++; $display("FAIL top_addr_resp got=%b exp=10", {resp_valid, resp_err}); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        resp_ready = 1'b0;
        send(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'h80AD_BEEF}) begin errors++; $display("FAIL stall_resp[%0d] got=%b/%b/%h exp=1/0/80adbeef", i, resp_valid, resp_err, resp_rdata); end
            checks++; if ({req_ready, mem_str, mem_ld} !== 3'b000) begin errors++; $display("FAIL stall_busy[%0d] got=%b exp=000", i, {req_ready, mem_str, mem_ld}); end
            if (i == 0) begin
                req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
                req_addr = 32'h0000_0020; req_wdata = 32'h5555_5555;
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++; if ({req_ready, resp_valid, mem_str} !== 3'b100) begin errors++; $display("FAIL stall_release got=%b exp=100", {req_ready, resp_valid, mem_str}); end
        @(negedge clk);
        checks++; if (mem[8] !== 32'h0) begin errors++; $display("FAIL stall_no_store got=%h exp=0", mem[8]); end
    endtask

    task automatic test_reset_mid;
        send(1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'h1234_5678);
        checks++; if (mem_str !== 1'b1) begin errors++; $display("FAIL rst_mid_issue got=%b exp=1", mem_str); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({req_ready, resp_valid, resp_err, mem_str, mem_ld, mem_sel} !== 9'b1_0000_0000) begin errors++; $display("FAIL rst_mid_ctl got=%b exp=100000000", {req_ready, resp_valid, resp_err, mem_str, mem_ld, mem_sel}); end
        checks++; if ({resp_rdata, mem_data_in, mem_addr} !== 84'h0) begin errors++; $display("FAIL rst_mid_data got=%h exp=0", {resp_rdata, mem_data_in, mem_addr}); end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++; if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("FAIL rst_mid_noresp got=%b exp=10", {req_ready, resp_valid}); end
        end
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1; rst_n = 1'b0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller sitting directly upstream of the data memory (word-addressed, 4-bit byte-select, synchronous 1-cycle registered read).
- Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake.
- Checks alignment and range, then generates the word address, byte-select and lane-replicated store data for the memory.
- Sign- or zero-extends the returned read data back to the pipeline over a valid/ready response channel.

Parameters:
- MEM_ADDR_BITS, 20, word-address width of the data memory; legal range 1..30.
- MEM_DATA_BITS, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  response present.
- resp_ready  input  1  pipeline accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned, out-of-range or reserved-size request.
- mem_addr  output  MEM_ADDR_BITS  word address to memory.
- mem_data_in  output  32  lane-replicated store data.
- mem_sel  output  4  byte-select.
- mem_str  output  1  memory write strobe.
- mem_ld  output  1  memory read enable.
- mem_data_out  input  32  memory registered read data, lanes in place and masked by sel.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: when rst_n is sampled low at a rising edge, state goes to IDLE. req_ready is 1 after reset. All other outputs and every captured register are 0. Reset aborts any in-flight access, including a pending response, with no memory side effect beyond an already-sampled strobe. The memory clear input is owned elsewhere and is not driven by this block.
- States: IDLE, ISSUE, RESP.
- IDLE: req_ready=1, all mem_* = 0.
  - On req_valid at an edge, capture the request.
  - If legal, go to ISSUE.
  - If illegal, go to RESP with err=1 and no memory access.
- Legality (any failure makes the request illegal):
  - size != 11.
  - half requires addr[0]=0.
  - word requires addr[1:0]=00.
  - addr[31:MEM_ADDR_BITS+2] must be all zero.
- ISSUE, one cycle:
  - mem_addr = addr[MEM_ADDR_BITS+1:2]; off = addr[1:0].
  - mem_sel: byte = 0001<<off; half = off[1] ? 1100 : 0011; word = 1111.
  - mem_data_in: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
  - Store: mem_str=1, mem_ld=0. Load: mem_ld=1, mem_str=0.
  - All mem_* come from registered state (no combinational path from req_*).
  - Next state is RESP unconditionally.
- RESP:
  - resp_valid=1 and all mem_* = 0. mem_data_out is captured into a response register on the first RESP cycle, so it holds stable while stalled.
  - Load result: byte = lane off, extended from bit 7; half = lane off[1], extended from bit 15; word = as is.
  - Stores return rdata=0, err=0. Errors return rdata=0, err=1.
  - Stay in RESP while resp_ready=0, with outputs stable. Go to IDLE on resp_ready.
- Latency and throughput:
  - Legal request accepted at edge k gives resp_valid in the cycle after edge k+1.
  - An error response appears in the cycle after edge k.
  - Throughput is one access per 3 cycles. req_ready is 0 outside IDLE, so no new request is accepted in the cycle a response is consumed.
- req_wdata and req_unsigned are ignored where they do not apply.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state encoding IDLE/ISSUE/RESP.
- One natural sub-module, lsu_align, is purely combinational and instantiated twice:
  - store side: (size, off, wdata) -> (sel, lane data).
  - load side: (size, off, unsigned, raw) -> extended data.

Test Plan:
1. Word store then word load:
   - store addr 0x0000_0010, wdata 0xDEADBEEF gives ISSUE with mem_addr=4, sel=1111, str=1.
   - load of the same address returns rdata=0xDEADBEEF two edges after accept, err=0.
2. Byte store and signed/unsigned load:
   - store byte 0x80 at addr 0x13 gives sel=1000, mem_data_in=0x80808080.
   - load byte signed at 0x13 gives 0xFFFFFF80.
   - load byte unsigned gives 0x00000080.
3. Half load: memory word 0x8001_7FFF at word 2.
   - half signed at 0x0A gives 0xFFFF8001.
   - half signed at 0x08 gives 0x00007FFF.
4. Errors:
   - half at 0x01, word at 0x02, size=11, and addr 0x0040_0000 (MEM_ADDR_BITS=20) each give resp_err=1 and rdata=0 one edge after accept.
   - mem_str and mem_ld stay 0 throughout.
5. Backpressure: load with resp_ready held 0 for 5 cycles.
   - resp_valid and resp_rdata stay stable.
   - req_ready=0 and a competing req_valid is not accepted.
   - the response completes on release.
6. Reset mid-operation: rst_n low during ISSUE of a store.
   - next cycle state is IDLE, req_ready=1, all other outputs 0, no response is issued.
